// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine plus arbiter for the shared external memory bus.
// The DMA copies OAM_LEN bytes from {src_hi,8'h00} into OAM while the CPU is limited to the FFxx page.
module oam_dma_arbiter #(
  parameter int          OAM_LEN      = 160,
  parameter int          START_DELAY  = 1,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [7:0]  LAST_IDX = 8'(OAM_LEN - 1);
  localparam logic [15:0] LAST_DLY = 16'(START_DELAY - 1);

  state_e      state_q;
  logic [7:0]  idx_q;
  logic [7:0]  src_hi_q;
  logic [7:0]  latch_q;
  logic [15:0] dly_q;
  logic        dma_active_q;

  logic cpu_acc_s;
  logic reg_hit_s;
  logic hi_acc_s;
  logic grant_s;

  assign cpu_acc_s  = cpu_rd | cpu_wr;
  assign reg_hit_s  = (cpu_addr == DMA_REG_ADDR);
  assign hi_acc_s   = cpu_acc_s & (cpu_addr[15:8] == 8'hFF) & ~reg_hit_s;
  // The FF46 register is never forwarded; a hi-page access also stalls the DMA in READ/WRITE.
  assign grant_s    = cpu_acc_s & ~reg_hit_s & ((state_q == ST_IDLE) | hi_acc_s);
  assign dma_active = dma_active_q;

  // Bus mux: granted CPU access first, otherwise the DMA strobe of the current phase.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    if (grant_s) begin
      bus_rd = cpu_rd & ~cpu_wr;
      bus_wr = cpu_wr;
    end else if (state_q == ST_READ) begin
      bus_addr = {src_hi_q, idx_q};
      bus_rd   = 1'b1;
    end else if (state_q == ST_WRITE) begin
      bus_addr  = OAM_BASE + {8'h00, idx_q};
      bus_wdata = latch_q;
      bus_wr    = 1'b1;
    end else begin
      bus_rd = 1'b0;
    end
  end

  // CPU read data: FF46 register, granted bus data, or open-bus 8'hFF when blocked.
  always_comb begin
    if (reg_hit_s) begin
      cpu_rdata = src_hi_q;
    end else if ((state_q == ST_IDLE) || hi_acc_s) begin
      cpu_rdata = bus_rdata;
    end else begin
      cpu_rdata = 8'hFF;
    end
  end

  // DMA sequencer with registered dma_active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 8'h00;
      src_hi_q     <= 8'hFF;
      latch_q      <= 8'h00;
      dly_q        <= 16'h0000;
      dma_active_q <= 1'b0;
    end else if (cpu_wr && reg_hit_s) begin
      // A trigger always restarts from the delay phase, even mid-transfer.
      state_q      <= ST_DELAY;
      idx_q        <= 8'h00;
      src_hi_q     <= cpu_wdata;
      latch_q      <= 8'h00;
      dly_q        <= 16'h0000;
      dma_active_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dma_active_q <= 1'b0;
        end
        ST_DELAY: begin
          if (dly_q == LAST_DLY) begin
            dly_q   <= 16'h0000;
            state_q <= ST_READ;
          end else begin
            dly_q <= dly_q + 16'h0001;
          end
        end
        ST_READ: begin
          if (!hi_acc_s) begin
            latch_q <= bus_rdata;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!hi_acc_s) begin
            if (idx_q == LAST_IDX) begin
              idx_q        <= 8'h00;
              state_q      <= ST_IDLE;
              dma_active_q <= 1'b0;
            end else begin
              idx_q   <= idx_q + 8'h01;
              state_q <= ST_READ;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          dma_active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench: a step-count reference model of the DMA/arbiter is compared with the DUT every cycle.
module tb_oam_dma_arbiter;

  localparam int OAM_LEN     = 160;
  localparam int START_DELAY = 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic [7:0]  dsrc [0:OAM_LEN-1];

  int checks;
  int failures;
  int act_cnt;
  int oam_wr_cnt;

  // Reference model: a transfer is START_DELAY idle cycles followed by 2*OAM_LEN numbered steps.
  logic        m_busy;
  int          m_delay;
  int          m_step;
  logic [7:0]  m_src;
  logic [7:0]  m_latch;
  logic        m_hi;

  oam_dma_arbiter #(
    .OAM_LEN(OAM_LEN), .START_DELAY(START_DELAY),
    .OAM_BASE(16'hFE00), .DMA_REG_ADDR(16'hFF46)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_rdata(bus_rdata), .dma_active(dma_active)
  );

  assign bus_rdata = mem[bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the bus; only bus writes change it.
  always @(posedge clk) begin
    if (bus_wr) begin
      mem[bus_addr] <= bus_wdata;
      if (bus_addr >= 16'hFE00 && bus_addr < 16'hFEA0) oam_wr_cnt = oam_wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (dma_active) act_cnt = act_cnt + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_delay = 0;
      m_step  = 0;
      m_src   = 8'hFF;
      m_latch = 8'h00;
    end else begin
      m_hi = (cpu_rd || cpu_wr) && cpu_addr[15:8] == 8'hFF && cpu_addr != 16'hFF46;
      if (cpu_wr && cpu_addr == 16'hFF46) begin
        m_src   = cpu_wdata;
        m_busy  = 1'b1;
        m_delay = START_DELAY;
        m_step  = 0;
        m_latch = 8'h00;
      end else if (m_busy) begin
        if (m_delay > 0) begin
          m_delay = m_delay - 1;
        end else if (!m_hi) begin
          if (m_step % 2 == 0) m_latch = mem[{m_src, 8'(m_step / 2)}];
          m_step = m_step + 1;
          if (m_step == 2 * OAM_LEN) begin
            m_busy = 1'b0;
            m_step = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of every meaningful DUT output against the model.
  initial begin
    logic        acc, reg_hit, hi, grant, e_rd, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_wd, e_rdata;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        acc     = cpu_rd | cpu_wr;
        reg_hit = (cpu_addr == 16'hFF46);
        hi      = acc && cpu_addr[15:8] == 8'hFF && !reg_hit;
        grant   = acc && !reg_hit && (!m_busy || hi);
        e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0000; e_wd = 8'h00;
        if (grant) begin
          e_rd = cpu_rd && !cpu_wr; e_wr = cpu_wr; e_addr = cpu_addr; e_wd = cpu_wdata;
        end else if (m_busy && m_delay == 0) begin
          if (m_step % 2 == 0) begin
            e_rd = 1'b1; e_addr = {m_src, 8'(m_step / 2)};
          end else begin
            e_wr = 1'b1; e_addr = 16'hFE00 + 16'(m_step / 2); e_wd = m_latch;
          end
        end
        e_rdata = reg_hit ? m_src : (grant ? mem[cpu_addr] : 8'hFF);
        check("dma_active", {15'd0, dma_active}, {15'd0, m_busy});
        check("bus_rd", {15'd0, bus_rd}, {15'd0, e_rd});
        check("bus_wr", {15'd0, bus_wr}, {15'd0, e_wr});
        if (e_rd || e_wr) check("bus_addr", bus_addr, e_addr);
        if (e_wr) check("bus_wdata", {8'd0, bus_wdata}, {8'd0, e_wd});
        if (cpu_rd && !cpu_wr) check("cpu_rdata", {8'd0, cpu_rdata}, {8'd0, e_rdata});
      end
    end
  end

  task automatic cyc(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    cyc(1'b1, 1'b0, a, 8'h00);
    #1;
    check(name, {8'd0, cpu_rdata}, {8'd0, exp});
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (dma_active && n < bound) begin
      idle();
      n = n + 1;
    end
    if (dma_active) check("wait_idle_timeout", 16'd1, 16'd0);
    idle();
  endtask

  task automatic clear_oam();
    for (int i = 0; i < OAM_LEN; i++) cyc(1'b0, 1'b1, 16'hFE00 + 16'(i), 8'h00);
  endtask

  initial begin
    int start, oam_snap;
    logic done;
    logic [7:0] v;
    checks = 0; failures = 0; act_cnt = 0; oam_wr_cnt = 0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    rd_check("reset_ff46", 16'hFF46, 8'hFF);
    check("reset_active", {15'd0, dma_active}, 16'd0);
    check("reset_bus_wr", {15'd0, bus_wr}, 16'd0);

    // Preload memory through the DUT while idle.
    for (int i = 0; i < OAM_LEN; i++) cyc(1'b0, 1'b1, 16'hC100 + 16'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < OAM_LEN; i++) begin
      v = 8'($urandom_range(0, 255));
      dsrc[i] = v;
      cyc(1'b0, 1'b1, 16'hD000 + 16'(i), v);
    end
    cyc(1'b0, 1'b1, 16'h8000, 8'h11);

    // Plain transfer with blocked low-page accesses.
    start = act_cnt;
    cyc(1'b0, 1'b1, 16'hFF46, 8'hC1);
    repeat (20) idle();
    cyc(1'b1, 1'b0, 16'hC000, 8'h00);
    cyc(1'b0, 1'b1, 16'h8000, 8'h33);
    wait_idle(1000);
    check("len_plain", 16'(act_cnt - start), 16'd321);
    for (int i = 0; i < OAM_LEN; i++) check("oam_plain", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i) ^ 8'h5A});
    check("mem_8000", {8'd0, mem[16'h8000]}, 16'h0011);
    rd_check("ff46_c1", 16'hFF46, 8'hC1);

    // Hi-page write during the WRITE of idx 10 stalls the DMA by one cycle.
    clear_oam();
    start = act_cnt;
    done = 1'b0;
    cyc(1'b0, 1'b1, 16'hFF46, 8'hC1);
    for (int n = 0; n < 1000 && (dma_active || n == 0); n++) begin
      @(posedge clk);
      #1;
      if (m_busy && m_delay == 0 && m_step == 21 && !done) begin
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hFF80; cpu_wdata = 8'h77; done = 1'b1;
      end else begin
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      end
    end
    wait_idle(10);
    check("len_stall", 16'(act_cnt - start), 16'd322);
    check("ff80", {8'd0, mem[16'hFF80]}, 16'h0077);
    for (int i = 0; i < OAM_LEN; i++) check("oam_stall", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i) ^ 8'h5A});

    // Retrigger at idx 50 with a new source page.
    start = act_cnt;
    done = 1'b0;
    cyc(1'b0, 1'b1, 16'hFF46, 8'hC1);
    for (int n = 0; n < 1000 && (dma_active || n == 0); n++) begin
      @(posedge clk);
      #1;
      if (m_busy && m_delay == 0 && m_step == 100 && !done) begin
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; done = 1'b1;
      end else begin
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      end
    end
    wait_idle(10);
    check("len_retrig", 16'(act_cnt - start), 16'd423);
    for (int i = 0; i < OAM_LEN; i++) check("oam_retrig", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, dsrc[i]});

    // Randomized CPU traffic around several transfers.
    for (int n = 0; n < 2500; n++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cyc(1'b0, 1'b1, 16'hFF46, 8'($urandom_range(0, 255)));
      end else if (r < 35) begin
        idle();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 40) a = {8'hFF, 8'($urandom_range(0, 255))};
        else if (r < 50) a = 16'hFF46;
        else a = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 1) == 1 || a == 16'hFF46) cyc(1'b1, 1'b0, a, 8'h00);
        else cyc(1'b0, 1'b1, a, 8'($urandom_range(0, 255)));
      end
    end
    wait_idle(1000);

    // Asynchronous reset in the middle of a transfer.
    clear_oam();
    cyc(1'b0, 1'b1, 16'hFF46, 8'hC1);
    for (int n = 0; n < 1000 && !(m_busy && m_delay == 0 && m_step == 160); n++) idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_active", {15'd0, dma_active}, 16'd0);
    check("rst_bus_rd", {15'd0, bus_rd}, 16'd0);
    check("rst_bus_wr", {15'd0, bus_wr}, 16'd0);
    oam_snap = oam_wr_cnt;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle();
    check("rst_no_oam_wr", 16'(oam_wr_cnt - oam_snap), 16'd0);
    check("rst_oam79", {8'd0, mem[16'hFE4F]}, {8'd0, 8'd79 ^ 8'h5A});
    check("rst_oam80", {8'd0, mem[16'hFE50]}, 16'h0000);
    rd_check("rst_ff46", 16'hFF46, 8'hFF);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Performs the OAM DMA transfer triggered by a CPU write to FF46: copies OAM_LEN bytes from {src_hi,8'h00} to OAM_BASE.
- Owns the shared external memory bus and arbitrates it between the CPU core's memory port and the DMA engine.
- While DMA runs, CPU access is restricted to the FF00–FFFF page; all other CPU accesses are blocked.
- Sits between the sm83 core's memory interface and the system bus/memory map.

Parameters:
- OAM_LEN, 160, bytes per transfer (1..256).
- START_DELAY, 1, idle cycles between the trigger and the first DMA read (≥1).
- OAM_BASE, 16'hFE00, destination base address.
- DMA_REG_ADDR, 16'hFF46, trigger/source register address.

Ports:
- clk in 1: system clock.
- rst_n in 1: reset. One clock; reset is asynchronous and active-low.
- cpu_addr in 16: CPU address.
- cpu_wdata in 8: CPU write data.
- cpu_rd in 1: CPU read strobe, one cycle per access.
- cpu_wr in 1: CPU write strobe, one cycle per access.
- cpu_rdata out 8: CPU read data, combinational.
- bus_addr out 16: shared bus address.
- bus_wdata out 8: shared bus write data.
- bus_rd out 1: shared bus read strobe.
- bus_wr out 1: shared bus write strobe.
- bus_rdata in 8: shared bus read data, combinational and valid in the same cycle as bus_rd.
- dma_active out 1: high while the FSM is not IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0, src_hi=8'hFF, data latch=0, dma_active=0. Bus outputs pass the CPU through (bus_rd=bus_wr=0 when the CPU is idle).
- FSM states and transitions:
  - IDLE: on a FF46 write, go to DELAY.
  - DELAY: counts START_DELAY cycles, then goes to READ.
  - READ: bus_addr={src_hi,idx}, bus_rd=1, bus_rdata captured into the latch at the edge; then goes to WRITE.
  - WRITE: bus_addr=OAM_BASE+idx, bus_wr=1, bus_wdata=latch.
  - From WRITE: if idx==OAM_LEN-1, go to IDLE with idx=0; else idx+1 and go to READ.
- Registered outputs: dma_active is registered from state; it rises on the edge that samples the trigger and falls on the edge that completes the last WRITE.
- Active length: START_DELAY + 2*OAM_LEN cycles when unstalled (321 at defaults).
- FF46 register:
  - A CPU write to DMA_REG_ADDR loads src_hi and is never forwarded to the bus.
  - A CPU read of DMA_REG_ADDR returns src_hi.
  - Both are legal in any state.
- Retrigger: a FF46 write while not IDLE reloads src_hi, sets idx=0, state=DELAY, discards the latch, and keeps dma_active high.
- Arbitration in IDLE: all other CPU accesses pass straight through to the bus; cpu_rdata=bus_rdata.
- Arbitration when not IDLE:
  - A CPU access with cpu_addr[15:8]==8'hFF (other than FF46) is "hi" and is granted the bus.
  - In DELAY a hi access uses the bus freely.
  - In READ/WRITE a hi access wins the cycle: the DMA holds state, idx and latch, and its strobe is suppressed that cycle (stall).
  - Any non-hi CPU access: reads return 8'hFF, writes are dropped, and nothing reaches the bus.
- Simultaneous cpu_rd and cpu_wr is illegal; cpu_wr takes priority.
- src_hi is used unclamped (E0–FF sources allowed).
- idx is 8 bits; OAM_BASE+idx uses 16-bit add with wrap.

Test Plan:
- Reset, then CPU reads FF46 → cpu_rdata=8'hFF, dma_active=0, bus_wr=0.
- Memory model C100+i=i^8'h5A; CPU writes FF46=8'hC1 → dma_active high for exactly 321 cycles; FE00+i==i^8'h5A for i=0..159; FF46 reads 8'hC1.
- During the transfer, CPU reads C000 → cpu_rdata=8'hFF with no bus_rd at C000; CPU writes 8000=8'h33 → no bus_wr to 8000, and 8000 is unchanged afterwards.
- CPU writes FF80=8'h77 during the WRITE phase of idx 10 → bus writes FF80=8'h77 that cycle; the DMA stalls 1 cycle, making dma_active 322 cycles; the OAM contents are still correct.
- Write FF46=8'hD0 while idx=50 → restart through DELAY; all FE00..FE9F end equal to D000..D09F; total active = 50*2+1+1+321 cycles from the first trigger.
- Assert rst_n low mid-transfer at idx=80 → dma_active=0 and bus strobes low immediately without waiting for the clock edge; FF46 reads 8'hFF; no further OAM writes.
